// File: rtl/mips_pkg.sv
// Shared types for the MIPS core: instruction field encodings, memory op codes and
// memory-controller error/state enums, plus lane helpers used by the memory controller.
package mips_pkg;

  typedef enum logic [5:0] {
    OPCODE_R      = 6'h00, OPCODE_REGIMM = 6'h01, OPCODE_J     = 6'h02, OPCODE_JAL   = 6'h03,
    OPCODE_BEQ    = 6'h04, OPCODE_BNE    = 6'h05, OPCODE_BLEZ  = 6'h06, OPCODE_BGTZ  = 6'h07,
    OPCODE_ADDIU  = 6'h09, OPCODE_SLTI   = 6'h0A, OPCODE_SLTIU = 6'h0B, OPCODE_ANDI  = 6'h0C,
    OPCODE_ORI    = 6'h0D, OPCODE_XORI   = 6'h0E, OPCODE_LUI   = 6'h0F, OPCODE_LB    = 6'h20,
    OPCODE_LH     = 6'h21, OPCODE_LWL    = 6'h22, OPCODE_LW    = 6'h23, OPCODE_LBU   = 6'h24,
    OPCODE_LHU    = 6'h25, OPCODE_LWR    = 6'h26, OPCODE_SB    = 6'h28, OPCODE_SH    = 6'h29,
    OPCODE_SW     = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FUNCTION_SLL  = 6'h00, FUNCTION_SRL  = 6'h02, FUNCTION_SRA  = 6'h03, FUNCTION_SLLV = 6'h04,
    FUNCTION_SRLV = 6'h06, FUNCTION_SRAV = 6'h07, FUNCTION_JR   = 6'h08, FUNCTION_JALR = 6'h09,
    FUNCTION_MFHI = 6'h10, FUNCTION_MTHI = 6'h11, FUNCTION_MFLO = 6'h12, FUNCTION_MTLO = 6'h13,
    FUNCTION_MULT = 6'h18, FUNCTION_MULTU = 6'h19, FUNCTION_DIV = 6'h1A, FUNCTION_DIVU = 6'h1B,
    FUNCTION_ADDU = 6'h21, FUNCTION_SUBU = 6'h23, FUNCTION_AND  = 6'h24, FUNCTION_OR   = 6'h25,
    FUNCTION_XOR  = 6'h26, FUNCTION_SLT  = 6'h2A, FUNCTION_SLTU = 6'h2B
  } function_t;

  typedef enum logic [4:0] {
    REGIMM_BLTZ   = 5'h00, REGIMM_BGEZ   = 5'h01, REGIMM_BLTZAL = 5'h10, REGIMM_BGEZAL = 5'h11
  } REGIMM_t;

  typedef enum logic [3:0] {
    NONE = 4'd0, FETCH, LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW
  } mem_op_t;

  typedef enum logic [1:0] {
    ERR_OK = 2'b00, ERR_MISALIGNED = 2'b01, ERR_TIMEOUT = 2'b10
  } mem_err_t;

  typedef enum logic [1:0] {StIdle, StBus, StResp} mem_state_t;

  function automatic logic is_store(mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic logic is_misaligned(mem_op_t op, logic [1:0] k);
    case (op)
      FETCH, LW:   return k != 2'd0;
      LH, LHU, SH: return k[0];
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(mem_op_t op, logic [1:0] k);
    case (op)
      LB, LBU, SB: return 4'b0001 << k;
      LH, LHU, SH: return k[1] ? 4'b1100 : 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

  // Sub-word stores replicate across all lanes; byteenable picks the live one.
  function automatic logic [31:0] store_data(mem_op_t op, logic [31:0] wdata);
    case (op)
      SB:      return {4{wdata[7:0]}};
      SH:      return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_ctrl_if.sv
// Core-side request/response and Avalon-MM master signals of the memory controller.
interface mips_mem_ctrl_if;
  import mips_pkg::*;

  logic        req_valid;
  logic        req_ready;
  mem_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt;
  logic        resp_valid;
  logic [31:0] resp_data;
  mem_err_t    resp_err;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rt, waitrequest, readdata,
    output req_ready, resp_valid, resp_data, resp_err, address, read, write, writedata,
           byteenable
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rt, waitrequest, readdata,
    input  req_ready, resp_valid, resp_data, resp_err, address, read, write, writedata,
           byteenable
  );
endinterface

// File: rtl/mips_load_align.sv
// Combinational load formatter: lane select, sign/zero extension and LWL/LWR merge with rt.
module mips_load_align import mips_pkg::*; (
  input  mem_op_t     op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] rt_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = word_i;
    case (op_i)
      LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU: data_o = {24'h0, byte_sel};
      LH:  data_o = {{16{half_sel[15]}}, half_sel};
      LHU: data_o = {16'h0, half_sel};
      // LWL fills from the top with the low bytes of the word; rt keeps the rest.
      LWL: begin
        case (offset_i)
          2'd0:    data_o = {word_i[7:0], rt_i[23:0]};
          2'd1:    data_o = {word_i[15:0], rt_i[15:0]};
          2'd2:    data_o = {word_i[23:0], rt_i[7:0]};
          default: data_o = word_i;
        endcase
      end
      LWR: begin
        case (offset_i)
          2'd0:    data_o = word_i;
          2'd1:    data_o = {rt_i[31:24], word_i[31:8]};
          2'd2:    data_o = {rt_i[31:16], word_i[31:16]};
          default: data_o = {rt_i[31:8], word_i[31:24]};
        endcase
      end
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mips_mem_ctrl.sv
// Turns one core memory request into one Avalon-MM read or write, with lane steering,
// load formatting, misalignment detection and an optional waitrequest watchdog.
module mips_mem_ctrl import mips_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input  logic           clk,
  input  logic           reset,
  mips_mem_ctrl_if.slave bus
);

  localparam bit                   TimeoutEn   = TIMEOUT_CYCLES != 0;
  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t           state_q, state_d;
  mem_op_t              op_q, op_d;
  logic [1:0]           offset_q, offset_d;
  logic [31:0]          rt_q, rt_d;
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [31:0]          address_q, address_d;
  logic [31:0]          writedata_q, writedata_d;
  logic [3:0]           byteenable_q, byteenable_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [31:0]          resp_data_q, resp_data_d;
  mem_err_t             resp_err_q, resp_err_d;
  logic [31:0]          load_data;
  logic                 req_take;

  mips_load_align u_load_align (
    .op_i     (op_q),
    .offset_i (offset_q),
    .word_i   (bus.readdata),
    .rt_i     (rt_q),
    .data_o   (load_data)
  );

  assign req_take = bus.req_valid && (bus.req_op != NONE) && (bus.req_op <= SW);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    offset_d     = offset_q;
    rt_d         = rt_q;
    wd_cnt_d     = wd_cnt_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      StIdle: begin
        if (req_take) begin
          op_d     = bus.req_op;
          offset_d = bus.req_addr[1:0];
          rt_d     = bus.req_rt;
          if (is_misaligned(bus.req_op, bus.req_addr[1:0])) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_data_d  = 32'h0;
            resp_err_d   = ERR_MISALIGNED;
          end else begin
            state_d      = StBus;
            wd_cnt_d     = '0;
            address_d    = {bus.req_addr[31:2], 2'b00};
            byteenable_d = lane_enable(bus.req_op, bus.req_addr[1:0]);
            read_d       = !is_store(bus.req_op);
            write_d      = is_store(bus.req_op);
            if (is_store(bus.req_op)) begin
              writedata_d = store_data(bus.req_op, bus.req_wdata);
            end
          end
        end
      end
      StBus: begin
        if (!bus.waitrequest) begin
          state_d      = StResp;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_data_d  = read_q ? load_data : 32'h0;
          resp_err_d   = ERR_OK;
        end else if (TimeoutEn && (wd_cnt_q == TimeoutLast)) begin
          state_d      = StResp;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_data_d  = 32'h0;
          resp_err_d   = ERR_TIMEOUT;
        end else if (TimeoutEn) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= NONE;
      offset_q     <= 2'd0;
      rt_q         <= 32'h0;
      wd_cnt_q     <= '0;
      address_q    <= 32'h0;
      writedata_q  <= 32'h0;
      byteenable_q <= 4'h0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= ERR_OK;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      offset_q     <= offset_d;
      rt_q         <= rt_d;
      wd_cnt_q     <= wd_cnt_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle) && !reset;
  assign bus.address    = address_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = byteenable_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Directed plus randomized bench for mips_mem_ctrl against an arithmetic reference model.
module tb_mips_mem_ctrl;
  import mips_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passes = 0;

  mips_mem_ctrl_if bus_if ();

  mips_mem_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_W      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic model_mis(mem_op_t op, int k);
    if (op == FETCH || op == LW) return k != 0;
    if (op == LH || op == LHU || op == SH) return (k % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(mem_op_t op, int k);
    if (op == LB || op == LBU || op == SB) return 4'(1 << k);
    if (op == LH || op == LHU || op == SH) return 4'(3 << k);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(mem_op_t op, logic [31:0] wd);
    if (op == SB) return (wd & 32'hFF) * 32'h01010101;
    if (op == SH) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(mem_op_t op, int k, logic [31:0] w, logic [31:0] r);
    longint unsigned lw = 64'(w);
    longint unsigned lr = 64'(r);
    int v;
    int s;
    case (op)
      LB, LBU: begin
        v = int'((lw >> (8 * k)) & 64'hFF);
        if (op == LB && v > 127) v -= 256;
        return 32'(v);
      end
      LH, LHU: begin
        v = int'((lw >> (8 * k)) & 64'hFFFF);
        if (op == LH && v > 32767) v -= 65536;
        return 32'(v);
      end
      LWL: begin
        s = 8 * (3 - k);
        return 32'(((lw << s) & 64'hFFFF_FFFF) | (lr & ((64'd1 << s) - 1)));
      end
      LWR: begin
        s = 8 * k;
        return 32'((lw >> s) | (lr & ~((64'd1 << (32 - s)) - 1)));
      end
      default: return w;
    endcase
  endfunction

  // Drives one request from a negedge and plays the Avalon slave with `waits` stall cycles.
  task automatic run_txn(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rt, input logic [31:0] rdata, input int waits);
    int          k;
    logic        mis;
    logic        st;
    logic        tmo;
    logic        stall;
    logic [31:0] exp_data;
    logic [31:0] exp_err;
    k   = int'(addr[1:0]);
    mis = model_mis(op, k);
    st  = op inside {SB, SH, SW};
    tmo = !mis && (waits >= TMO);
    chk("ready_idle", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wdata;
    bus_if.req_rt    = rt;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = NONE;
    bus_if.req_addr  = $urandom;
    bus_if.req_wdata = $urandom;
    bus_if.req_rt    = $urandom;
    if (!mis) begin
      for (int c = 0; c < TMO; c++) begin
        stall = (c < waits);
        chk("read", 32'(bus_if.read), 32'(!st));
        chk("write", 32'(bus_if.write), 32'(st));
        chk("address", bus_if.address, addr & 32'hFFFF_FFFC);
        chk("byteenable", 32'(bus_if.byteenable), 32'(model_be(op, k)));
        if (st) chk("writedata", bus_if.writedata, model_wd(op, wdata));
        chk("no_resp_bus", 32'(bus_if.resp_valid), 32'd0);
        chk("ready_bus", 32'(bus_if.req_ready), 32'd0);
        bus_if.waitrequest = stall;
        bus_if.readdata    = stall ? $urandom : rdata;
        @(negedge clk);
        if (!stall) break;
      end
      bus_if.waitrequest = 1'b0;
      bus_if.readdata    = $urandom;
    end
    exp_err  = mis ? 32'd1 : (tmo ? 32'd2 : 32'd0);
    exp_data = (mis || tmo || st) ? 32'h0 : model_load(op, k, rdata, rt);
    chk("resp_valid", 32'(bus_if.resp_valid), 32'd1);
    chk("resp_err", 32'(bus_if.resp_err), exp_err);
    chk("resp_data", bus_if.resp_data, exp_data);
    chk("strobes_off", {30'h0, bus_if.read, bus_if.write}, 32'd0);
    chk("ready_resp", 32'(bus_if.req_ready), 32'd0);
    @(negedge clk);
    chk("resp_one_cycle", 32'(bus_if.resp_valid), 32'd0);
  endtask

  initial begin
    mem_op_t ops [11] = '{FETCH, LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW};
    reset               = 1'b1;
    bus_if.req_valid    = 1'b0;
    bus_if.req_op       = NONE;
    bus_if.req_addr     = 32'h0;
    bus_if.req_wdata    = 32'h0;
    bus_if.req_rt       = 32'h0;
    bus_if.waitrequest  = 1'b0;
    bus_if.readdata     = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_read", 32'(bus_if.read), 32'd0);
    chk("rst_write", 32'(bus_if.write), 32'd0);
    chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("rst_address", bus_if.address, 32'd0);
    chk("rst_writedata", bus_if.writedata, 32'd0);
    chk("rst_byteenable", 32'(bus_if.byteenable), 32'd0);
    chk("rst_resp_data", bus_if.resp_data, 32'd0);
    chk("rst_resp_err", 32'(bus_if.resp_err), 32'd0);
    chk("rst_ready", 32'(bus_if.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // NONE is ignored: no strobe and no response.
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = NONE;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    chk("none_ignored", {29'h0, bus_if.read, bus_if.write, bus_if.resp_valid}, 32'd0);

    run_txn(LW,  32'h0000_0100, 32'h0,         32'h0,         32'hDEAD_BEEF, 0);
    run_txn(LB,  32'h0000_0103, 32'h0,         32'h0,         32'h80FF_FFFF, 0);
    run_txn(LBU, 32'h0000_0103, 32'h0,         32'h0,         32'h80FF_FFFF, 1);
    run_txn(SH,  32'h0000_0202, 32'h1234_ABCD, 32'h0,         32'h0,         3);
    run_txn(LWL, 32'h0000_0301, 32'h0,         32'hAABB_CCDD, 32'h4433_2211, 0);
    run_txn(LWR, 32'h0000_0302, 32'h0,         32'hAABB_CCDD, 32'h4433_2211, 0);
    run_txn(LH,  32'h0000_0401, 32'h0,         32'h0,         32'h0,         0);
    run_txn(LW,  32'h0000_0404, 32'h0,         32'h0,         32'h1111_2222, 20);

    // Reset while a store is stalled abandons it.
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = SW;
    bus_if.req_addr  = 32'h0000_0500;
    bus_if.req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_if.req_valid   = 1'b0;
    bus_if.req_op      = NONE;
    bus_if.waitrequest = 1'b1;
    chk("sw_write_stall", 32'(bus_if.write), 32'd1);
    @(negedge clk);
    chk("sw_write_held", 32'(bus_if.write), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_write", 32'(bus_if.write), 32'd0);
    chk("rst_mid_resp", 32'(bus_if.resp_valid), 32'd0);
    chk("rst_mid_ready", 32'(bus_if.req_ready), 32'd0);
    reset              = 1'b0;
    bus_if.waitrequest = 1'b0;
    @(negedge clk);
    chk("post_rst_resp", 32'(bus_if.resp_valid), 32'd0);
    run_txn(SB, 32'h0000_0601, 32'h0000_00A5, 32'h0, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      run_txn(ops[$urandom_range(0, 10)], $urandom, $urandom, $urandom, $urandom,
              int'($urandom_range(0, 5)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  always @(negedge clk) begin
    if (bus_if.read && bus_if.write) begin
      chk("read_write_excl", 32'd1, 32'd0);
    end
  end

endmodule

// File: doc/mips_mem_ctrl.md
# mips_mem_ctrl

Multi-op memory access unit between the multi-cycle MIPS core and its Avalon memory-mapped master port. It turns one core request into one Avalon read or write: instruction fetch, LB/LBU/LH/LHU/LW/LWL/LWR, or SB/SH/SW. It handles `waitrequest` stalls, byte-lane steering, load extension/merge and misalignment detection. An optional watchdog aborts transfers stalled by `waitrequest`. It generalises the single-word bus access of `mips_cpu_bus` and is instantiated once inside it.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 0: maximum consecutive `waitrequest` cycles before abort; 0 disables the watchdog.
- `TIMEOUT_W`, default 16: watchdog counter width; `TIMEOUT_CYCLES` must be < 2^`TIMEOUT_W`.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  core request strobe.
- `req_ready`  out  1  controller can accept a request.
- `req_op`  in  4  `mem_op_t` operation code.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data (low byte/half used for SB/SH).
- `req_rt`  in  32  current rt value, merged by LWL/LWR.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_data`  out  32  load/fetch result; 0 for stores and errors.
- `resp_err`  out  2  `mem_err_t`: 00 OK, 01 MISALIGNED, 10 TIMEOUT.
- `address`  out  32  Avalon word address (`req_addr` with [1:0] = 0).
- `read`  out  1  Avalon read strobe.
- `write`  out  1  Avalon write strobe.
- `waitrequest`  in  1  Avalon stall.
- `writedata`  out  32  Avalon write data.
- `byteenable`  out  4  Avalon lane enables.
- `readdata`  in  32  Avalon read data.

## Operation
- Memory is little-endian: byte offset k = `req_addr[1:0]` maps to lane k, bits [8k+7:8k].
- **IDLE:** `req_ready`=1. When `req_valid` is high, latch op/addr/wdata/rt.
  - Misaligned request → RESP with MISALIGNED. Misaligned means FETCH/LW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1.
  - Otherwise → BUS.
  - `req_op`=NONE is ignored.
- **BUS:** drive `address` and `byteenable`, and drive `writedata` for stores. Assert `read` (fetch/loads) or `write` (stores).
  - While `waitrequest`=1, hold every Avalon output stable.
  - On the first cycle with `waitrequest`=0: capture `readdata`, deassert strobes next edge, go to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle, then → IDLE. `req_ready`=0 in BUS and RESP.
- Read byteenables:
  - FETCH/LW/LWL/LWR: 1111.
  - LB/LBU: 1<<k.
  - LH/LHU: 0011 (k=0) or 1100 (k=2).
- Write byteenables are the same lane patterns. `writedata` replicates the byte (SB) ×4 or the half (SH) ×2.
- Load results:
  - LB/LH: sign-extend the selected lane(s). LBU/LHU: zero-extend.
  - LW/FETCH: the whole word.
  - LWL, word w, rt r: (w << 8(3−k)) | (r & (2^(8(3−k))−1)).
  - LWR: (w >> 8k) | (r & ~(2^(32−8k)−1)); for k=0, result = w.
- Watchdog (`TIMEOUT_CYCLES`>0):
  - The counter clears on entry to BUS and increments each BUS cycle with `waitrequest`=1.
  - Reaching `TIMEOUT_CYCLES` drops the strobes at the next edge and goes to RESP with TIMEOUT, `resp_data`=0.
- Reset in any state, including mid-BUS: next edge → IDLE, strobes 0, no `resp_valid`. The pending transaction is abandoned.

## Timing
- Reset values: `read`, `write`, `resp_valid`=0; `address`, `writedata`, `byteenable`, `resp_data`, `resp_err`=0. `req_ready`=0 while `reset`=1.
- Request accepted at edge N → strobe visible in cycle N+1. With zero wait states, `resp_valid` is in cycle N+2. Each wait cycle adds 1.
- Misaligned: `resp_valid` in cycle N+1; no Avalon strobe is ever asserted.
- `read` and `write` are never high simultaneously. Avalon outputs are registered; no combinational path from `req_*` to Avalon outputs.
- `readdata` is sampled only in the cycle where `read`=1 and `waitrequest`=0.

## Structure
- Package `mips_pkg`: `mem_op_t` (NONE, FETCH, LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW), `mem_err_t`, FSM state enum.
- The existing `opcode_t`, `function_t` and `REGIMM_t` typedefs also move into `mips_pkg`.
- Sub-module `mips_load_align`: purely combinational lane select, extend and LWL/LWR merge. It is unit-tested separately.

## Test plan
- LW at 0x100, `waitrequest` low, `readdata`=0xDEADBEEF → `read` for 1 cycle, `byteenable`=1111, `resp_data`=0xDEADBEEF at N+2, `resp_err`=00.
- LB at 0x103, `readdata`=0x80FFFFFF → `byteenable`=1000, `resp_data`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, `req_wdata`=0x1234ABCD, `waitrequest` high for 3 cycles → `write` held 4 cycles, `address`=0x200, `byteenable`=1100, `writedata`=0xABCDABCD stable throughout; `resp_valid` at N+5.
- LWL at 0x301, `readdata`=0x44332211, rt=0xAABBCCDD → 0x2211CCDD. LWR at 0x302, same readdata and rt → 0xAABB4433.
- LH at 0x401 → no strobe, `resp_err`=01 at N+1. `TIMEOUT_CYCLES`=4 with `waitrequest` stuck high → `read` drops after 4 stall cycles, `resp_err`=10.
- `reset` asserted during a stalled SW → `write`=0 next edge, no `resp_valid`; the next request is accepted normally.
